irrigation_system: RTL and testbench
====================================

// Module: irrigation_system
//
// PURPOSE
// - Soil-moisture irrigation controller with one clock domain.
// - Samples a 4-bit moisture sensor and drives a pump enable.
// - Watering starts when the soil is dry. It stops when the soil is wet or a watering timeout expires.
// - A mandatory soak period follows every watering burst; no re-evaluation happens during it.
// - Sits between the sensor ADC front end and the pump relay driver.
//
// PARAMETERS
// - THRESHOLD  4'd4  moisture level; sensor < THRESHOLD means dry.
// - DELAY      20    soak length in clk cycles after watering; legal range 1..255.
// - MAX_WATER  16    maximum cycles in one watering burst; legal range 1..255.
//
// PORTS
// - clk        in   1  system clock; all logic on the rising edge.
// - reset      in   1  synchronous, active-high reset.
// - sensor     in   4  moisture reading; unsigned, 0 = driest.
// - pump       out  1  pump enable; 1 = watering.
// - state      out  2  status: 0 = IDLE, 1 = WATER, 2 = SOAK (3 is unused).
// - dry_fault  out  1  sticky flag: the last burst ended on timeout.
//
// BEHAVIOUR
// - Reset (sampled at a rising edge):
//   - state = IDLE, internal cycle counter (8 bits) = 0, pump = 0, dry_fault = 0.
//   - Reset takes priority over every transition, including mid-WATER and mid-SOAK.
//   - pump is 0 from the first edge at which reset is sampled high.
// - pump is decoded from the registered state: pump = (state == WATER). No combinational path from sensor to pump.
// - IDLE:
//   - sensor < THRESHOLD at an edge -> WATER, counter cleared to 0.
//   - pump rises 1 cycle after the dry sample.
//   - Otherwise stay in IDLE.
// - WATER: the counter increments every cycle. Evaluate the exits in this order:
//   1. sensor >= THRESHOLD -> SOAK, counter = 0, dry_fault cleared to 0.
//   2. else counter == MAX_WATER-1 -> SOAK, counter = 0, dry_fault set to 1.
//   3. else stay in WATER.
// - Burst length: pump is high for at most MAX_WATER cycles per burst.
// - SOAK:
//   - pump = 0; sensor is ignored.
//   - The counter increments each cycle. At counter == DELAY-1 -> IDLE, counter = 0.
//   - SOAK therefore lasts exactly DELAY cycles.
// - Boundary conditions:
//   - sensor == THRESHOLD counts as wet; there is no hysteresis.
//   - A wet sample and the timeout in the same cycle: the wet exit wins and dry_fault is cleared.
//   - Sensor still dry when SOAK ends: IDLE re-enters WATER on the next edge. IDLE therefore lasts 1 cycle.
//   - The counter never wraps, because both limits are at most 255.
//   - Unused state encoding 3 returns to IDLE on the next edge with pump = 0.
//   - The sensor is sampled as-is; no debounce.
//
// TESTING (default parameters, 10 ns clk)
// - Reset held 2 cycles with sensor = 4'b0010 -> pump = 0, state = IDLE, dry_fault = 0 throughout reset.
// - Release reset, sensor = 4'b0010 -> pump = 1 one cycle later. Drive sensor = 4'b0101 after 5 cycles -> pump = 0 within 2 cycles, state = SOAK, dry_fault = 0.
// - After SOAK, sensor = 4'b1100 for 5 cycles -> pump stays 0, state = IDLE. Then sensor = 4'b0001 -> pump = 1 on the next cycle.
// - From IDLE, hold sensor = 4'b0001 -> pump high for exactly 16 cycles, then 0 with dry_fault = 1. At 20 cycles pump is still 0 (SOAK).
// - sensor = 4'b0100 (equal to THRESHOLD) in IDLE -> no watering. sensor = 4'b0100 during WATER -> exit to SOAK.
// - Assert reset in the middle of WATER -> pump = 0 and state = IDLE from that edge. Assert reset in the middle of SOAK -> a dry sensor restarts watering right after reset releases.

Source files
------------

// File: rtl/irrigation_system_if.sv
// Sensor-to-controller bus: moisture reading in, pump enable and status out.
interface irrigation_system_if;
  logic [3:0] sensor;
  logic       pump;
  logic [1:0] state;
  logic       dry_fault;

  // master: sensor front end / observer side; slave: the controller
  modport master (output sensor, input pump, input state, input dry_fault);
  modport slave  (input sensor, output pump, output state, output dry_fault);
endinterface

// File: rtl/irrigation_system.sv
// Soil-moisture irrigation controller: water while dry, bounded burst length,
// then a fixed soak period before the sensor is looked at again.
module irrigation_system #(
  parameter logic [3:0]  THRESHOLD = 4'd4,
  parameter int unsigned DELAY     = 20,
  parameter int unsigned MAX_WATER = 16
) (
  input logic               clk,
  input logic               reset,
  irrigation_system_if.slave bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] SOAK_LAST  = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] WATER_LAST = CNT_W'(MAX_WATER - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WATER = 2'd1,
    SOAK  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pump_q;
  logic             dry_fault_q;

  // pump_q is updated with state_q so it always equals (state_q == WATER)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pump_q      <= 1'b0;
      dry_fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.sensor < THRESHOLD) begin
            state_q <= WATER;
            pump_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        WATER: begin
          // wet exit has priority over the timeout exit
          if (bus.sensor >= THRESHOLD) begin
            state_q     <= SOAK;
            pump_q      <= 1'b0;
            cnt_q       <= '0;
            dry_fault_q <= 1'b0;
          end else if (cnt_q == WATER_LAST) begin
            state_q     <= SOAK;
            pump_q      <= 1'b0;
            cnt_q       <= '0;
            dry_fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SOAK: begin
          if (cnt_q == SOAK_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          pump_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.pump      = pump_q;
  assign bus.state     = state_q;
  assign bus.dry_fault = dry_fault_q;

endmodule

// File: tb/tb_irrigation_system.sv
// Directed bench for irrigation_system with a phase/countdown reference model
// compared on every falling edge, plus literal checkpoints.
module tb_irrigation_system;

  localparam int unsigned DELAY     = 20;
  localparam int unsigned MAX_WATER = 16;

  logic clk = 1'b0;
  logic reset;
  int   vecs = 0;
  int   errs = 0;

  irrigation_system_if bus();

  irrigation_system #(
    .THRESHOLD (4'd4),
    .DELAY     (DELAY),
    .MAX_WATER (MAX_WATER)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: phase 0 idle, 1 watering, 2 soaking; burst counts pumped
  // cycles so far, soak_left counts down the remaining soak cycles.
  int m_phase     = 0;
  int m_burst     = 0;
  int m_soak_left = 0;
  int m_fault     = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_burst = 0; m_soak_left = 0; m_fault = 0;
    end else begin
      case (m_phase)
        0: if (int'(bus.sensor) < 4) begin m_phase = 1; m_burst = 1; end
        1: begin
          if (int'(bus.sensor) >= 4) begin
            m_phase = 2; m_soak_left = DELAY; m_fault = 0;
          end else if (m_burst == MAX_WATER) begin
            m_phase = 2; m_soak_left = DELAY; m_fault = 1;
          end else begin
            m_burst = m_burst + 1;
          end
        end
        default: begin
          m_soak_left = m_soak_left - 1;
          if (m_soak_left == 0) m_phase = 0;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset !== 1'bx) begin
      chk("model_pump",  {3'b0, bus.pump},      (m_phase == 1) ? 4'd1 : 4'd0);
      chk("model_state", {2'b0, bus.state},     4'(m_phase));
      chk("model_fault", {3'b0, bus.dry_fault}, 4'(m_fault));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic p, input logic [1:0] s, input logic f);
    chk({name, "_pump"},  {3'b0, bus.pump},      {3'b0, p});
    chk({name, "_state"}, {2'b0, bus.state},     {2'b0, s});
    chk({name, "_fault"}, {3'b0, bus.dry_fault}, {3'b0, f});
  endtask

  initial begin
    reset = 1'b1;
    bus.sensor = 4'b0010;
    cyc(1);
    expect_out("reset1", 1'b0, 2'd0, 1'b0);
    cyc(1);
    expect_out("reset2", 1'b0, 2'd0, 1'b0);

    // dry after release: pump one edge later, then wet after 5 cycles
    reset = 1'b0;
    cyc(1);
    expect_out("start", 1'b1, 2'd1, 1'b0);
    cyc(4);
    bus.sensor = 4'b0101;
    cyc(1);
    expect_out("wet_exit", 1'b0, 2'd2, 1'b0);

    // soak lasts DELAY cycles regardless of sensor
    bus.sensor = 4'b1100;
    cyc(DELAY - 1);
    expect_out("soak_end_m1", 1'b0, 2'd2, 1'b0);
    cyc(1);
    expect_out("soak_done", 1'b0, 2'd0, 1'b0);
    cyc(5);
    expect_out("idle_wet", 1'b0, 2'd0, 1'b0);

    // full-length dry burst: exactly MAX_WATER pump cycles then timeout
    bus.sensor = 4'b0001;
    cyc(1);
    expect_out("burst0", 1'b1, 2'd1, 1'b0);
    for (int i = 1; i < MAX_WATER; i++) begin
      cyc(1);
      chk("burst_pump", {3'b0, bus.pump}, 4'd1);
    end
    cyc(1);
    expect_out("timeout", 1'b0, 2'd2, 1'b1);
    cyc(3);
    expect_out("soak_after_to", 1'b0, 2'd2, 1'b1);

    // still dry at soak end: one IDLE cycle then watering again
    cyc(DELAY - 4);
    expect_out("soak_last", 1'b0, 2'd2, 1'b1);
    cyc(1);
    expect_out("idle_1cyc", 1'b0, 2'd0, 1'b1);
    cyc(1);
    expect_out("rewater", 1'b1, 2'd1, 1'b1);

    // wet sample coinciding with the timeout edge: wet wins, fault clears
    cyc(MAX_WATER - 1);
    bus.sensor = 4'b0100;
    cyc(1);
    expect_out("wet_vs_to", 1'b0, 2'd2, 1'b0);

    // sensor == threshold is wet in IDLE and in WATER
    cyc(DELAY);
    expect_out("eq_idle", 1'b0, 2'd0, 1'b0);
    cyc(3);
    expect_out("eq_idle_hold", 1'b0, 2'd0, 1'b0);
    bus.sensor = 4'b0010;
    cyc(3);
    bus.sensor = 4'b0100;
    cyc(1);
    expect_out("eq_water", 1'b0, 2'd2, 1'b0);

    // reset during WATER
    cyc(DELAY);
    bus.sensor = 4'b0011;
    cyc(3);
    expect_out("pre_rst_water", 1'b1, 2'd1, 1'b0);
    reset = 1'b1;
    cyc(1);
    expect_out("rst_water", 1'b0, 2'd0, 1'b0);
    reset = 1'b0;

    // reset during SOAK, dry sensor restarts immediately after release
    cyc(1);
    bus.sensor = 4'b1000;
    cyc(1);
    cyc(5);
    expect_out("pre_rst_soak", 1'b0, 2'd2, 1'b0);
    bus.sensor = 4'b0001;
    reset = 1'b1;
    cyc(1);
    expect_out("rst_soak", 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    cyc(1);
    expect_out("restart", 1'b1, 2'd1, 1'b0);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
